// File: rtl/phy_pkg.sv
// Shared types and constants for the PHY byte serializer.
// The state enum and the frame length helper are also used by anything
// that needs to know how long a serial frame is on the wire.
package phy_pkg;

  // Default idle/alignment symbol (K28.5-style COM byte).
  localparam logic [7:0] COM_SYM_DEF = 8'hBC;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Bits per serial frame: data bits, plus one when parity is appended.
  function automatic int frame_len(input int data_w, input bit parity_en);
    return parity_en ? data_w + 1 : data_w;
  endfunction

endpackage

// File: rtl/phy_byte_serializer.sv
// Byte-to-serial converter behind the lane mux. MSB first, one bit per clk,
// back-to-back frames. After reset SYNC_COMS COM frames go out before any
// data is accepted; afterwards a COM fills every frame boundary where no
// byte is offered.
// Optional feature: define SER_PARITY_EN to append an even-parity bit after
// the LSB of every frame (COM frames included).
module phy_byte_serializer
  import phy_pkg::*;
#(
  parameter int                 DATA_W    = 8,
  parameter logic [DATA_W-1:0]  COM_SYM   = DATA_W'(COM_SYM_DEF),
  parameter int                 SYNC_COMS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_out,
  output logic              data_out,
  output logic              frame_start,
  output logic              is_com,
  output logic              active_out
);

`ifdef SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int FRAME_LEN = frame_len(DATA_W, PAR_EN);
  localparam int BCW       = $clog2(FRAME_LEN);
  localparam int CCW       = $clog2(SYNC_COMS + 1);

  localparam logic [BCW-1:0] BIT_LAST = BCW'(FRAME_LEN - 1);
  localparam logic [CCW-1:0] COM_LAST = CCW'(SYNC_COMS - 1);

  state_e                 state_q, state_d;
  logic [CCW-1:0]         com_cnt_q, com_cnt_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [FRAME_LEN-2:0]   shift_q, shift_d;
  logic                   dout_q, dout_d;
  logic                   fs_q, fs_d;
  logic                   is_com_q, is_com_d;

  logic                   load;
  logic                   sel_data;
  logic [DATA_W-1:0]      byte_sel;
  logic [FRAME_LEN-1:0]   word;

  // Frame word for the next load: offered byte when ACTIVE, COM otherwise.
  always_comb begin
    load     = (bit_cnt_q == BIT_LAST);
    sel_data = (state_q == ACTIVE) && valid_in;
    byte_sel = sel_data ? data_in : COM_SYM;
`ifdef SER_PARITY_EN
    word     = {byte_sel, ^byte_sel};
`else
    word     = byte_sel;
`endif
  end

  // Next-state: load a new frame at the last bit, otherwise keep shifting.
  always_comb begin
    state_d   = state_q;
    com_cnt_d = com_cnt_q;
    bit_cnt_d = bit_cnt_q + BCW'(1);
    shift_d   = shift_q << 1;
    dout_d    = shift_q[FRAME_LEN-2];
    fs_d      = 1'b0;
    is_com_d  = is_com_q;
    if (load) begin
      bit_cnt_d = '0;
      dout_d    = word[FRAME_LEN-1];
      shift_d   = word[FRAME_LEN-2:0];
      fs_d      = 1'b1;
      is_com_d  = ~sel_data;
      // The last sync COM both goes out and opens the data path on this edge.
      if (state_q == SYNC) begin
        com_cnt_d = com_cnt_q + CCW'(1);
        if (com_cnt_q == COM_LAST) state_d = ACTIVE;
      end
    end
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SYNC;
      com_cnt_q <= '0;
      bit_cnt_q <= BIT_LAST;
      shift_q   <= '0;
      dout_q    <= 1'b0;
      fs_q      <= 1'b0;
      is_com_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      com_cnt_q <= com_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      dout_q    <= dout_d;
      fs_q      <= fs_d;
      is_com_q  <= is_com_d;
    end
  end

  assign data_out    = dout_q;
  assign frame_start = fs_q;
  assign is_com      = is_com_q;
  assign active_out  = (state_q == ACTIVE);
  // Independent of valid_in so the mux upstream can use it freely.
  assign ready_out   = (state_q == ACTIVE) && (bit_cnt_q == BIT_LAST);

endmodule

// File: tb/tb_phy_byte_serializer.sv
// Directed bench for phy_byte_serializer: sync sequence, data frames,
// back-to-back bytes, COM fill, mid-frame reset. Follows SER_PARITY_EN.
module tb_phy_byte_serializer;

`ifdef SER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [7:0] data_in;
  logic       ready_out, data_out, frame_start, is_com, active_out;

  int checks = 0;
  int errors = 0;

  phy_byte_serializer dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .ready_out   (ready_out),
    .data_out    (data_out),
    .frame_start (frame_start),
    .is_com      (is_com),
    .active_out  (active_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full frame starting at the next edge (a load edge). The byte offered
  // is flipped right after the load to show mid-frame changes are ignored.
  task automatic frame(input logic [7:0] b, input bit com, input bit act);
    logic [FL-1:0] w;
`ifdef SER_PARITY_EN
    w = {b, ^b};
`else
    w = b;
`endif
    for (int i = 0; i < FL; i++) begin
      step();
      chk("data_out",    32'(data_out),    32'(w[FL-1-i]));
      chk("frame_start", 32'(frame_start), 32'(i == 0));
      chk("is_com",      32'(is_com),      32'(com));
      chk("active_out",  32'(active_out),  32'(act));
      chk("ready_out",   32'(ready_out),   32'(act && (i == FL-1)));
      if (i == 0) data_in = ~data_in;
    end
  endtask

  task automatic chk_reset_state();
    chk("rst data_out",    32'(data_out),    32'(0));
    chk("rst frame_start", 32'(frame_start), 32'(0));
    chk("rst is_com",      32'(is_com),      32'(0));
    chk("rst ready_out",   32'(ready_out),   32'(0));
    chk("rst active_out",  32'(active_out),  32'(0));
  endtask

  initial begin
    logic [7:0] a5;
    a5       = 8'hA5;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    repeat (3) step();
    chk_reset_state();

    // Sync: four COM frames, ACTIVE entered at the load of the fourth.
    reset = 1'b0;
    frame(8'hBC, 1'b1, 1'b0);
    frame(8'hBC, 1'b1, 1'b0);
    frame(8'hBC, 1'b1, 1'b0);
    frame(8'hBC, 1'b1, 1'b1);

    // First data byte, then back-to-back bytes with valid held.
    valid_in = 1'b1;
    data_in  = 8'hA5; frame(8'hA5, 1'b0, 1'b1);
    data_in  = 8'h01; frame(8'h01, 1'b0, 1'b1);
    data_in  = 8'hFF; frame(8'hFF, 1'b0, 1'b1);

    // Idle boundary between two bytes gets a COM; nothing lost or repeated.
    data_in  = 8'h3C; frame(8'h3C, 1'b0, 1'b1);
    valid_in = 1'b0;  frame(8'hBC, 1'b1, 1'b1);
    valid_in = 1'b1;
    data_in  = 8'h5A; frame(8'h5A, 1'b0, 1'b1);

    // Reset during bit 3 of 0xA5 aborts the frame.
    data_in = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pre-rst bit", 32'(data_out), 32'(a5[7-i]));
    end
    reset = 1'b1;
    step();
    chk_reset_state();

    // After release four COMs precede data even with valid held.
    reset = 1'b0;
    frame(8'hBC, 1'b1, 1'b0);
    frame(8'hBC, 1'b1, 1'b0);
    frame(8'hBC, 1'b1, 1'b0);
    frame(8'hBC, 1'b1, 1'b1);
    data_in = 8'hA5; frame(8'hA5, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
